pc_sequencer: RTL

Parametrised program-counter sequencer for the processor front end; the next generation of the simple enable-gated PC. It adds a configurable PC width and reset vector, relative branches, absolute jumps, call/return through a small return-address stack, and a halt/resume state machine. It sits between decode/control (which drives the control strobes) and instruction memory (which is addressed by `pc`).

---
 rtl/pc_seq_pkg.sv | 27 ++
 rtl/ras_stack.sv | 65 ++++++
 rtl/pc_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_seq_pkg
// Brief    : Shared types and constants for the program-counter sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package pc_seq_pkg;

    localparam int RAS_DEPTH_DEF = 4;
    localparam int RAS_CNT_W     = $clog2(RAS_DEPTH_DEF + 1);

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } pc_state_e;

    typedef enum logic [2:0] {
        HOLD   = 3'd0,
        INC    = 3'd1,
        BRANCH = 3'd2,
        JUMP   = 3'd3,
        CALL   = 3'd4,
        RET    = 3'd5
    } pc_act_e;

endpackage
`default_nettype wire

// File: rtl/ras_stack.sv
`default_nettype none
// ============================================================================
// Module   : ras_stack
// Brief    : Circular return-address LIFO; a push when full overwrites the oldest entry.
// Revision : 1.0 - initial release
// ============================================================================
module ras_stack
    import pc_seq_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = RAS_DEPTH_DEF,
    parameter int CNT_W = RAS_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] c_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_top_ptr;
    logic [PTR_W-1:0] w_next_ptr;

    // r_wr_ptr is the next free slot; the top of stack sits just below it.
    assign w_top_ptr  = (r_wr_ptr == '0) ? c_LAST : r_wr_ptr - PTR_W'(1);
    assign w_next_ptr = (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + PTR_W'(1);

    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign top   = r_mem[w_top_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (push) begin
            r_wr_ptr <= w_next_ptr;
            if (!full) begin
                r_count <= r_count + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            r_wr_ptr <= w_top_ptr;
            r_count  <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Brief    : Program counter with branch/jump/call/return and halt/resume control.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              PC_W      = 9,
    parameter int              OFF_W     = 8,
    parameter int              RAS_DEPTH = RAS_DEPTH_DEF,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic                             branch,
    input  logic [OFF_W-1:0]                 offset,
    input  logic                             jump,
    input  logic [PC_W-1:0]                  target,
    input  logic                             call,
    input  logic                             ret,
    input  logic                             halt,
    input  logic                             resume,
    output logic [PC_W-1:0]                  pc,
    output logic                             halted,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
    output logic                             ras_full,
    output logic                             ras_empty,
    output logic                             ras_ovf,
    output logic                             ras_unf
);

    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    pc_state_e        r_state;
    pc_state_e        w_state_nxt;
    pc_act_e          w_act;
    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  w_pc_nxt;
    logic [PC_W-1:0]  w_pc_inc;
    logic [PC_W-1:0]  w_off_ext;
    logic [PC_W-1:0]  w_ras_top;
    logic             r_ovf;
    logic             r_unf;
    logic             w_push;
    logic             w_pop;

    assign w_pc_inc  = r_pc + PC_W'(1);
    assign w_off_ext = PC_W'(signed'(offset));

    // Priority decode; halt wins over every other strobe and produces no PC change.
    always_comb begin
        w_act = HOLD;
        if (r_state == RUN && enable && !halt) begin
            if (ret)         w_act = RET;
            else if (call)   w_act = CALL;
            else if (jump)   w_act = JUMP;
            else if (branch) w_act = BRANCH;
            else             w_act = INC;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (enable && halt) w_state_nxt = HALTED;
            HALTED:  if (resume)         w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    always_comb begin
        w_pc_nxt = r_pc;
        case (w_act)
            INC:     w_pc_nxt = w_pc_inc;
            BRANCH:  w_pc_nxt = r_pc + w_off_ext;
            JUMP:    w_pc_nxt = target;
            CALL:    w_pc_nxt = target;
            RET:     w_pc_nxt = ras_empty ? w_pc_inc : w_ras_top;
            default: w_pc_nxt = r_pc;
        endcase
    end

    assign w_push = (w_act == CALL);
    assign w_pop  = (w_act == RET) && !ras_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
            r_pc    <= RESET_PC;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_push && ras_full)                r_ovf <= 1'b1;
            if ((w_act == RET) && ras_empty)       r_unf <= 1'b1;
        end
    end

    ras_stack #(
        .WIDTH (PC_W),
        .DEPTH (RAS_DEPTH),
        .CNT_W (CNT_W)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pc_inc),
        .top       (w_ras_top),
        .count     (ras_count),
        .full      (ras_full),
        .empty     (ras_empty)
    );

    assign pc      = r_pc;
    assign halted  = (r_state == HALTED);
    assign ras_ovf = r_ovf;
    assign ras_unf = r_unf;

endmodule
`default_nettype wire
